// File: rtl/avalon_byte_mem_pkg.sv
// Shared types, widths and helpers for the Avalon-MM byte memory slave.
// Optional stall FSM is enabled with AVALON_BYTE_MEM_STALL_EN.
package avalon_byte_mem_pkg;

    localparam int AVM_ADDR_W = 32;
    localparam int AVM_DATA_W = 8;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        ACK   = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/avalon_byte_mem_slave_byte_ram.sv
// DEPTH x 8 single-port byte RAM; synchronous write.
// Read is registered with AVALON_BYTE_MEM_STALL_EN, combinational otherwise.
module byte_ram
    import avalon_byte_mem_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
`ifdef AVALON_BYTE_MEM_STALL_EN
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic                  rd_zero,
`endif
    input  logic                  we,
    input  logic [IDX_W-1:0]      addr,
    input  logic [AVM_DATA_W-1:0] wdata,
    output logic [AVM_DATA_W-1:0] rdata
);

    logic [AVM_DATA_W-1:0] mem_q [DEPTH];

    // Byte store; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

`ifdef AVALON_BYTE_MEM_STALL_EN
    logic [AVM_DATA_W-1:0] rdata_q;
    logic [AVM_DATA_W-1:0] rdata_d;

    // Load the read byte (or zero for a rejected address) only when asked.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = rd_zero ? '0 : mem_q[addr];
        end
    end

    // Output register holds its value between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
`else
    assign rdata = mem_q[addr];
`endif

endmodule

// File: rtl/avalon_byte_mem_slave.sv
// Avalon-MM byte memory slave with stall generation, transfer counters and
// error flags. Define AVALON_BYTE_MEM_STALL_EN for the waitrequest FSM build.
module avalon_byte_mem_slave
    import avalon_byte_mem_pkg::*;
#(
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AVM_ADDR_W-1:0] avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [AVM_DATA_W-1:0] avs_writedata,
    output logic [AVM_DATA_W-1:0] avs_readdata,
    output logic                  avs_waitrequest,
    output logic [CNT_W-1:0]      rd_count,
    output logic [CNT_W-1:0]      wr_count,
    output logic                  protocol_err,
    output logic                  range_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [AVM_ADDR_W-1:0] DEPTH_A = AVM_ADDR_W'(DEPTH);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 255) begin : g_bad_wait
        $error("WAIT_CYCLES must be within 0..255");
    end

    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic                  perr_q, perr_d;
    logic                  rerr_q, rerr_d;
    logic                  ram_we;
    logic [IDX_W-1:0]      ram_addr;
    logic [AVM_DATA_W-1:0] ram_rdata;
    logic                  cmd;
    logic                  oor_in;

    assign cmd    = avs_read | avs_write;
    assign oor_in = (avs_address >= DEPTH_A);

`ifdef AVALON_BYTE_MEM_STALL_EN
    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [AVM_ADDR_W-1:0] addr_q, addr_d;
    logic                  is_wr_q, is_wr_d;
    logic                  wait_q, wait_d;
    logic                  ram_rd_en;
    logic                  ram_rd_zero;
    logic                  oor_q;

    assign oor_q    = (addr_q >= DEPTH_A);
    assign ram_addr = (state_q == IDLE) ? avs_address[IDX_W-1:0]
                                        : addr_q[IDX_W-1:0];

    // Handshake FSM: latch command, count stalls, police hold rules, complete.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        is_wr_d     = is_wr_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        perr_d      = perr_q;
        rerr_d      = rerr_q;
        ram_we      = 1'b0;
        ram_rd_en   = 1'b0;
        ram_rd_zero = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd) begin
                    addr_d  = avs_address;
                    is_wr_d = avs_write;
                    if (avs_read && avs_write) begin
                        perr_d = 1'b1;
                    end
                    if (WAIT_CYCLES == 0) begin
                        state_d     = ACK;
                        ram_rd_en   = !avs_write;
                        ram_rd_zero = oor_in;
                    end else begin
                        cnt_d   = 8'(WAIT_CYCLES - 1);
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (!cmd || avs_address != addr_q
                    || avs_write != is_wr_q) begin
                    perr_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d     = ACK;
                    ram_rd_en   = !is_wr_q;
                    ram_rd_zero = oor_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
                if (is_wr_q) begin
                    wr_cnt_d = sat_inc(wr_cnt_q);
                    ram_we   = !oor_q;
                end else begin
                    rd_cnt_d = sat_inc(rd_cnt_q);
                end
                if (oor_q) begin
                    rerr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        wait_d = (state_d != ACK);
    end

    // FSM state, latched command and registered waitrequest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            is_wr_q <= 1'b0;
            wait_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            is_wr_q <= is_wr_d;
            wait_q  <= wait_d;
        end
    end

    assign avs_waitrequest = wait_q;
    assign avs_readdata    = ram_rdata;

    byte_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (ram_rd_en),
        .rd_zero (ram_rd_zero),
        .we      (ram_we),
        .addr    (ram_addr),
        .wdata   (avs_writedata),
        .rdata   (ram_rdata)
    );
`else
    assign ram_addr = avs_address[IDX_W-1:0];

    // Zero-wait slave: every cycle carrying a command is a completed transfer.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        perr_d   = perr_q;
        rerr_d   = rerr_q;
        ram_we   = 1'b0;
        if (avs_write) begin
            wr_cnt_d = sat_inc(wr_cnt_q);
            ram_we   = !oor_in;
        end else if (avs_read) begin
            rd_cnt_d = sat_inc(rd_cnt_q);
        end
        if (avs_read && avs_write) begin
            perr_d = 1'b1;
        end
        if (cmd && oor_in) begin
            rerr_d = 1'b1;
        end
    end

    assign avs_waitrequest = 1'b0;
    assign avs_readdata    = oor_in ? '0 : ram_rdata;

    byte_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (avs_writedata),
        .rdata (ram_rdata)
    );
`endif

    // Transfer counters and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            perr_q   <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            perr_q   <= perr_d;
            rerr_q   <= rerr_d;
        end
    end

    assign rd_count     = rd_cnt_q;
    assign wr_count     = wr_cnt_q;
    assign protocol_err = perr_q;
    assign range_err    = rerr_q;

endmodule

// File: doc/avalon_byte_mem_slave.md
# avalon_byte_mem_slave

Avalon-MM slave byte memory: the responder end of the 8-bit-data, 32-bit-address master interface used by the RSA accelerator to read operands and write results. It stores DEPTH bytes, generates programmable waitrequest stalls, and counts completed transfers. It flags protocol violations and out-of-range accesses. It sits on the interconnect as the accelerator's operand/result buffer and doubles as the bus-functional responder in block-level benches.

## Interface
- DEPTH, 512, bytes of storage; the valid address range is 0..DEPTH-1.
- WAIT_CYCLES, 1, extra stall cycles per transfer (0..255).
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- avs_address  in  32  byte address
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_writedata  in  8  write byte
- avs_readdata  out  8  read byte, valid while waitrequest low on a read
- avs_waitrequest  out  1  stall; transfer completes in the cycle it is low
- rd_count  out  16  completed reads, saturating
- wr_count  out  16  completed writes, saturating
- protocol_err  out  1  sticky; master violated hold rules
- range_err  out  1  sticky; address >= DEPTH accessed

## Operation
- Reset values:
  - avs_waitrequest=1, avs_readdata=0, rd_count=0, wr_count=0, protocol_err=0, range_err=0, state IDLE.
  - Memory contents are not reset.
- FSM states: IDLE, STALL, ACK. avs_waitrequest = (state != ACK).
- IDLE, command present (read|write):
  - WAIT_CYCLES==0: go to ACK.
  - Otherwise: load cnt=WAIT_CYCLES-1 and go to STALL.
  - Latch the address and command type.
- STALL:
  - cnt==0: go to ACK. Otherwise cnt-1.
  - If the command drops: protocol_err=1, return to IDLE, no transfer.
  - If the address or command type changes from the latched values: protocol_err=1, abort to IDLE.
- Entry to ACK: on a read, register mem[addr] into avs_readdata.
- ACK:
  - Write: store avs_writedata.
  - Increment the matching counter, saturating at 16'hFFFF.
  - Return to IDLE unconditionally.
- Read and write both asserted: treat as a write and set protocol_err.
- Address >= DEPTH:
  - The transfer completes normally, with the same handshake timing.
  - A write is discarded. A read returns 8'h00.
  - range_err=1. The counter still increments.
- avs_readdata holds its last value outside read ACKs.
- The memory index is address[$clog2(DEPTH)-1:0], used only after the range check.
- Reset mid-transfer: the FSM returns to IDLE at once, no write lands, and the master must reissue.

## Timing
- Command first seen in cycle 0 in IDLE:
  - avs_waitrequest is high in cycles 0..WAIT_CYCLES.
  - It is low in cycle WAIT_CYCLES+1 (ACK).
  - Total occupancy is WAIT_CYCLES+2 cycles.
- Back-to-back: the next command is seen in the IDLE cycle after ACK, giving 1 bubble per transfer.
- The write lands at the clk edge ending ACK. A read of the same address issued next returns the new byte.
- Counters and sticky flags update at the edge ending ACK, or at the edge ending the violating cycle.

## Configuration
- AVALON_BYTE_MEM_STALL_EN defined: FSM, WAIT_CYCLES stalls and synchronous RAM read as described above.
- AVALON_BYTE_MEM_STALL_EN undefined:
  - avs_waitrequest is tied to 0 and the FSM is removed.
  - Every cycle with read or write is a completed transfer.
  - avs_readdata = mem[addr] combinationally (register-array storage).
  - The range, counter and simultaneous read/write rules are unchanged.
  - protocol_err is set only for simultaneous read/write.

## Structure
- Package avalon_byte_mem_pkg holds:
  - the state enum (IDLE/STALL/ACK);
  - AVM_ADDR_W=32, AVM_DATA_W=8, CNT_W=16;
  - the saturating-increment function.
- Sub-module byte_ram: DEPTH x 8, single port, synchronous write. Read is synchronous when STALL_EN is defined, asynchronous otherwise.

## Test plan
- Write 0xA5 to address 5 with WAIT_CYCLES=1 -> waitrequest high 2 cycles, low 1, wr_count=1; read address 5 -> readdata=0xA5 in its ACK cycle, rd_count=1.
- Write bytes 0..319 sequentially, then read them back, as the RSA master's fill/drain pattern -> all data matches, counts are 320/320, no error flags.
- Write 0x3C to address 600 with DEPTH=512 -> range_err=1, location 600%512=88 unchanged, read of 600 returns 0x00.
- Drop avs_read in the first STALL cycle with WAIT_CYCLES=3 -> protocol_err=1, rd_count unchanged, FSM in IDLE next cycle.
- Assert reset during STALL of a write of 0x77 to address 9 -> waitrequest=1, counters 0, and address 9 keeps its prior value.
- Build without AVALON_BYTE_MEM_STALL_EN, issue write then read of address 2 on consecutive cycles -> waitrequest stays 0 and readdata=written byte in the read cycle.
